// File: rtl/rx_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// rx_cmd_ctrl
//
// Command sequencer between the UART receiver's parallel byte output and the
// system register file / transmit FIFO. Command frames arrive one byte at a
// time on the Rx pulse interface and are turned into single-cycle register
// file writes or reads. Read data is pushed into the Tx FIFO.
//
// Frames:
//   OP_WR  addr data   single register write
//   OP_RD  addr        single register read, result pushed to Tx FIFO
//   OP_BRD addr count  burst read of 'count' consecutive registers
//
// Corrupted bytes, unknown opcodes, a zero burst count and stalled frames
// (no byte for TIMEOUT_CYC cycles) abort the frame and pulse Frame_error.
//
// Optional feature (macro RX_CMD_ERR_CNT_EN):
//   Adds Err_count[7:0], a saturating count of Frame_error pulses. It is
//   cleared by a good OP_WR frame to the all-ones address with data 8'h00
//   (that write still takes place).
//
// Ports:
//   CLK               system clock
//   Reset             asynchronous active-low reset
//   Rx_P_Data         received byte, valid when Rx_Data_valid=1
//   Rx_Data_valid     one-cycle pulse per received byte
//   Rx_Parity_error   qualifies current Rx byte
//   Rx_stop_error     qualifies current Rx byte
//   RF_WrEn           register-file write strobe (one cycle)
//   RF_RdEn           register-file read strobe (one cycle)
//   RF_Address        register-file address
//   RF_WrData         register-file write data
//   RF_RdData         register-file read data
//   RF_RdData_valid   read data valid, at least one cycle after RF_RdEn
//   Tx_FIFO_wr        FIFO push strobe (one cycle)
//   Tx_FIFO_data      FIFO push data
//   Tx_FIFO_full      FIFO full, holds the push while high
//   Busy              high in any state other than IDLE
//   Frame_error       one-cycle pulse on any frame abort
//   Err_count         saturating abort counter (RX_CMD_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
module rx_cmd_ctrl #(
    parameter int         ADDR_W      = 4,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [7:0] OP_WR       = 8'hAA,
    parameter logic [7:0] OP_RD       = 8'hBB,
    parameter logic [7:0] OP_BRD      = 8'hDD
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        Rx_P_Data,
    input  logic              Rx_Data_valid,
    input  logic              Rx_Parity_error,
    input  logic              Rx_stop_error,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [7:0]        RF_WrData,
    input  logic [7:0]        RF_RdData,
    input  logic              RF_RdData_valid,
    output logic              Tx_FIFO_wr,
    output logic [7:0]        Tx_FIFO_data,
    input  logic              Tx_FIFO_full,
    output logic              Busy,
    output logic              Frame_error
`ifdef RX_CMD_ERR_CNT_EN
    ,
    output logic [7:0]        Err_count
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_BRD_ADDR,
        S_BRD_CNT,
        S_RD_REQ,
        S_RD_WAIT,
        S_PUSH
    } state_t;

    state_t r_state, w_state_nxt;

    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic [7:0]        r_cnt,     w_cnt_nxt;
    logic [7:0]        r_rdata,   w_rdata_nxt;
    logic [7:0]        r_wdata,   w_wdata_nxt;
    logic [7:0]        r_fdata,   w_fdata_nxt;
    logic              r_wr_en,   w_wr_en_nxt;
    logic              r_rd_en,   w_rd_en_nxt;
    logic              r_push,    w_push_nxt;
    logic              r_ferr,    w_ferr_nxt;
    logic              r_busy;
    logic [TMO_W-1:0]  r_tmo;

    logic w_good;
    logic w_bad;
    logic w_collecting;
    logic w_read_seq;
    logic w_tmo_hit;

    assign w_good = Rx_Data_valid & ~Rx_Parity_error & ~Rx_stop_error;
    assign w_bad  = Rx_Data_valid & (Rx_Parity_error | Rx_stop_error);

    // States that are waiting for the next byte of a frame.
    assign w_collecting = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA) ||
                          (r_state == S_RD_ADDR) || (r_state == S_BRD_ADDR) ||
                          (r_state == S_BRD_CNT);

    assign w_read_seq = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                        (r_state == S_PUSH);

    // Expiry only counts when no byte arrives in the same cycle, so a byte
    // that lands exactly on the deadline is still accepted.
    assign w_tmo_hit = w_collecting && !Rx_Data_valid &&
                       (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

    // ---------------------------------------------------------------------
    // Next-state and strobe decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_rdata_nxt = r_rdata;
        w_wdata_nxt = r_wdata;
        w_fdata_nxt = r_fdata;
        w_wr_en_nxt = 1'b0;
        w_rd_en_nxt = 1'b0;
        w_push_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_good) begin
                    if (Rx_P_Data == OP_WR) begin
                        w_state_nxt = S_WR_ADDR;
                    end else if (Rx_P_Data == OP_RD) begin
                        w_state_nxt = S_RD_ADDR;
                    end else if (Rx_P_Data == OP_BRD) begin
                        w_state_nxt = S_BRD_ADDR;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else if (w_bad) begin
                    w_ferr_nxt = 1'b1;
                end
            end

            S_WR_ADDR: begin
                if (w_good) begin
                    w_addr_nxt  = Rx_P_Data[ADDR_W-1:0];
                    w_state_nxt = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                if (w_good) begin
                    w_wr_en_nxt = 1'b1;
                    w_wdata_nxt = Rx_P_Data;
                    w_state_nxt = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                if (w_good) begin
                    w_addr_nxt  = Rx_P_Data[ADDR_W-1:0];
                    w_cnt_nxt   = 8'd1;
                    w_state_nxt = S_RD_REQ;
                end
            end

            S_BRD_ADDR: begin
                if (w_good) begin
                    w_addr_nxt  = Rx_P_Data[ADDR_W-1:0];
                    w_state_nxt = S_BRD_CNT;
                end
            end

            S_BRD_CNT: begin
                if (w_good) begin
                    if (Rx_P_Data != 8'd0) begin
                        w_cnt_nxt   = Rx_P_Data;
                        w_state_nxt = S_RD_REQ;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            S_RD_REQ: begin
                w_rd_en_nxt = 1'b1;
                w_state_nxt = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (RF_RdData_valid) begin
                    w_rdata_nxt = RF_RdData;
                    w_state_nxt = S_PUSH;
                end
            end

            S_PUSH: begin
                // A full FIFO simply parks us here; r_rdata is held intact.
                if (!Tx_FIFO_full) begin
                    w_push_nxt  = 1'b1;
                    w_fdata_nxt = r_rdata;
                    w_cnt_nxt   = r_cnt - 8'd1;
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = (r_cnt == 8'd1) ? S_IDLE : S_RD_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Aborts while collecting a frame override whatever the case chose;
        // a bad byte or expiry can never coincide with a good byte.
        if (w_collecting && (w_bad || w_tmo_hit)) begin
            w_state_nxt = S_IDLE;
            w_wr_en_nxt = 1'b0;
            w_ferr_nxt  = 1'b1;
        end

        // Stray bytes during a read sequence are flagged but do not disturb it.
        if (w_read_seq && Rx_Data_valid) begin
            w_ferr_nxt = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State, datapath and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= 8'd0;
            r_rdata <= 8'd0;
            r_wdata <= 8'd0;
            r_fdata <= 8'd0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_push  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
            r_wdata <= w_wdata_nxt;
            r_fdata <= w_fdata_nxt;
            r_wr_en <= w_wr_en_nxt;
            r_rd_en <= w_rd_en_nxt;
            r_push  <= w_push_nxt;
            r_ferr  <= w_ferr_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    // Inter-byte timeout: only advances while a frame is being collected
    // and restarts on every received byte, good or bad.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_tmo <= '0;
        end else if (!w_collecting || Rx_Data_valid) begin
            r_tmo <= '0;
        end else if (!w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end

    assign RF_WrEn      = r_wr_en;
    assign RF_RdEn      = r_rd_en;
    assign RF_Address   = r_addr;
    assign RF_WrData    = r_wdata;
    assign Tx_FIFO_wr   = r_push;
    assign Tx_FIFO_data = r_fdata;
    assign Busy         = r_busy;
    assign Frame_error  = r_ferr;

`ifdef RX_CMD_ERR_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating abort counter
    // ---------------------------------------------------------------------
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic       w_err_clr;
    logic [7:0] r_err_cnt;

    // Magic clear frame: OP_WR to the all-ones address with data 8'h00.
    assign w_err_clr = (r_state == S_WR_DATA) && w_good &&
                       (r_addr == {ADDR_W{1'b1}}) && (Rx_P_Data == 8'h00);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_clr) begin
            r_err_cnt <= 8'd0;
        end else if (w_ferr_nxt) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign Err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
module tb_rx_cmd_ctrl;

    localparam int ADDR_W = 4;
    localparam int TMO    = 32;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [7:0]        Rx_P_Data;
    logic              Rx_Data_valid;
    logic              Rx_Parity_error;
    logic              Rx_stop_error;
    logic              RF_WrEn;
    logic              RF_RdEn;
    logic [ADDR_W-1:0] RF_Address;
    logic [7:0]        RF_WrData;
    logic [7:0]        RF_RdData;
    logic              RF_RdData_valid;
    logic              Tx_FIFO_wr;
    logic [7:0]        Tx_FIFO_data;
    logic              Tx_FIFO_full;
    logic              Busy;
    logic              Frame_error;
`ifdef RX_CMD_ERR_CNT_EN
    logic [7:0]        Err_count;
`endif

    rx_cmd_ctrl #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .Rx_P_Data       (Rx_P_Data),
        .Rx_Data_valid   (Rx_Data_valid),
        .Rx_Parity_error (Rx_Parity_error),
        .Rx_stop_error   (Rx_stop_error),
        .RF_WrEn         (RF_WrEn),
        .RF_RdEn         (RF_RdEn),
        .RF_Address      (RF_Address),
        .RF_WrData       (RF_WrData),
        .RF_RdData       (RF_RdData),
        .RF_RdData_valid (RF_RdData_valid),
        .Tx_FIFO_wr      (Tx_FIFO_wr),
        .Tx_FIFO_data    (Tx_FIFO_data),
        .Tx_FIFO_full    (Tx_FIFO_full),
        .Busy            (Busy),
        .Frame_error     (Frame_error)
`ifdef RX_CMD_ERR_CNT_EN
        ,
        .Err_count       (Err_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-file contents the model returns on reads.
    logic [7:0] rdmem [16];

    // Bus monitor: log every strobe away from the active edge.
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];
    logic [7:0] push_q[$];
    int         n_ferr    = 0;
    int         n_pwf     = 0;
    logic       full_prev = 1'b0;

    always @(negedge CLK) begin
        if (RF_WrEn) begin
            wr_addr_q.push_back(8'(RF_Address));
            wr_data_q.push_back(RF_WrData);
        end
        if (RF_RdEn) rd_addr_q.push_back(8'(RF_Address));
        if (Tx_FIFO_wr) begin
            push_q.push_back(Tx_FIFO_data);
            if (full_prev) n_pwf <= n_pwf + 1;
        end
        if (Frame_error) n_ferr <= n_ferr + 1;
        full_prev <= Tx_FIFO_full;
    end

    // Register-file model: data returned two cycles after the read strobe.
    initial begin
        logic [3:0] a;
        RF_RdData       = 8'h00;
        RF_RdData_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (RF_RdEn) begin
                a = RF_Address;
                @(posedge CLK); #1;
                @(posedge CLK); #1;
                RF_RdData       = rdmem[a];
                RF_RdData_valid = 1'b1;
                @(posedge CLK); #1;
                RF_RdData_valid = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic pe, input logic se);
        @(posedge CLK); #1;
        Rx_P_Data       = b;
        Rx_Data_valid   = 1'b1;
        Rx_Parity_error = pe;
        Rx_stop_error   = se;
        @(posedge CLK); #1;
        Rx_Data_valid   = 1'b0;
        Rx_Parity_error = 1'b0;
        Rx_stop_error   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int k;
        k = 0;
        @(negedge CLK);
        while (Busy && k < maxc) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, Busy, 0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        int bw, br, bp, bf, bpf, k;
        Reset           = 1'b0;
        Rx_P_Data       = 8'h00;
        Rx_Data_valid   = 1'b0;
        Rx_Parity_error = 1'b0;
        Rx_stop_error   = 1'b0;
        Tx_FIFO_full    = 1'b0;
        for (int i = 0; i < 16; i++) rdmem[i] = 8'h40 + 8'(i);
        rdmem[2]  = 8'h77;
        rdmem[3]  = 8'h33;
        rdmem[14] = 8'hE1;
        rdmem[15] = 8'hF2;
        rdmem[0]  = 8'hA0;

        // Reset state
        repeat (3) @(posedge CLK); #1;
        chk("reset_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Tx_FIFO_wr,
                              Tx_FIFO_data, Busy, Frame_error}, 0);
`ifdef RX_CMD_ERR_CNT_EN
        chk("reset_errcnt", Err_count, 0);
`endif
        Reset = 1'b1;
        repeat (2) @(posedge CLK); #1;

        // Single write AA,05,3C
        bw = wr_addr_q.size(); bf = n_ferr;
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        chk("wr_busy_mid", Busy, 1);
        send(8'h3C, 0, 0);
        chk("wr_en", RF_WrEn, 1);
        chk("wr_addr", RF_Address, 4'h5);
        chk("wr_data", RF_WrData, 8'h3C);
        chk("wr_busy_after", Busy, 0);
        @(posedge CLK); #1;
        chk("wr_en_one_cycle", RF_WrEn, 0);
        repeat (2) @(posedge CLK); #1;
        chk("wr_count", wr_addr_q.size() - bw, 1);
        chk("wr_no_ferr", n_ferr - bf, 0);

        // Single read BB,02
        br = rd_addr_q.size(); bp = push_q.size(); bf = n_ferr;
        send(8'hBB, 0, 0);
        send(8'h02, 0, 0);
        wait_idle("rd_idle", 60);
        chk("rd_count", rd_addr_q.size() - br, 1);
        chk("rd_addr", rd_addr_q[br], 8'h02);
        chk("rd_push_count", push_q.size() - bp, 1);
        chk("rd_push_data", push_q[bp], 8'h77);
        chk("rd_no_ferr", n_ferr - bf, 0);

        // Burst read DD,0E,03 with the FIFO full during the second push
        br = rd_addr_q.size(); bp = push_q.size(); bf = n_ferr; bpf = n_pwf;
        send(8'hDD, 0, 0);
        send(8'h0E, 0, 0);
        send(8'h03, 0, 0);
        k = 0;
        while (push_q.size() == bp && k < 60) begin
            @(negedge CLK);
            k++;
        end
        chk("brd_first_push_seen", push_q.size() - bp, 1);
        @(posedge CLK); #1;
        Tx_FIFO_full = 1'b1;
        repeat (10) @(posedge CLK); #1;
        chk("brd_held_while_full", push_q.size() - bp, 1);
        Tx_FIFO_full = 1'b0;
        wait_idle("brd_idle", 100);
        chk("brd_rd_count", rd_addr_q.size() - br, 3);
        chk("brd_rd_a0", rd_addr_q[br],     8'h0E);
        chk("brd_rd_a1", rd_addr_q[br + 1], 8'h0F);
        chk("brd_rd_a2", rd_addr_q[br + 2], 8'h00);
        chk("brd_push_count", push_q.size() - bp, 3);
        chk("brd_push_d0", push_q[bp],     8'hE1);
        chk("brd_push_d1", push_q[bp + 1], 8'hF2);
        chk("brd_push_d2", push_q[bp + 2], 8'hA0);
        chk("brd_push_while_full", n_pwf - bpf, 0);
        chk("brd_no_ferr", n_ferr - bf, 0);

        // Parity error on data byte aborts, next clean frame works
        bw = wr_addr_q.size(); bf = n_ferr;
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        send(8'h3C, 1, 0);
        chk("perr_ferr_now", Frame_error, 1);
        chk("perr_busy", Busy, 0);
        chk("perr_no_wren", RF_WrEn, 0);
        send(8'hAA, 0, 0);
        send(8'h01, 0, 0);
        send(8'h11, 0, 0);
        chk("perr_next_addr", RF_Address, 4'h1);
        chk("perr_next_data", RF_WrData, 8'h11);
        repeat (2) @(posedge CLK); #1;
        chk("perr_wr_count", wr_addr_q.size() - bw, 1);
        chk("perr_ferr_count", n_ferr - bf, 1);

        // Bytes arriving exactly on the timeout deadline still win
        bf = n_ferr;
        send(8'hAA, 0, 0);
        repeat (TMO - 2) @(posedge CLK);
        send(8'h05, 0, 0);
        repeat (TMO - 2) @(posedge CLK);
        send(8'h3C, 0, 0);
        chk("tmo_edge_wren", RF_WrEn, 1);
        chk("tmo_edge_addr", RF_Address, 4'h5);
        repeat (2) @(posedge CLK); #1;
        chk("tmo_edge_no_ferr", n_ferr - bf, 0);

        // Silence after AA,05 times out
        bw = wr_addr_q.size(); bf = n_ferr;
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        repeat (TMO + 4) @(posedge CLK); #1;
        chk("tmo_ferr", n_ferr - bf, 1);
        chk("tmo_busy", Busy, 0);
        chk("tmo_no_wr", wr_addr_q.size() - bw, 0);

        // Unknown opcode
        bf = n_ferr;
        send(8'h12, 0, 0);
        chk("badop_ferr_now", Frame_error, 1);
        chk("badop_busy", Busy, 0);
        repeat (2) @(posedge CLK); #1;
        chk("badop_ferr_count", n_ferr - bf, 1);

        // Zero burst count
        br = rd_addr_q.size(); bf = n_ferr;
        send(8'hDD, 0, 0);
        send(8'h00, 0, 0);
        send(8'h00, 0, 0);
        repeat (6) @(posedge CLK); #1;
        chk("brd0_ferr", n_ferr - bf, 1);
        chk("brd0_no_rd", rd_addr_q.size() - br, 0);
        chk("brd0_busy", Busy, 0);

        // Stray byte during a read: flagged, read still completes
        bp = push_q.size(); bf = n_ferr;
        send(8'hBB, 0, 0);
        send(8'h03, 0, 0);
        send(8'h99, 0, 0);
        wait_idle("stray_idle", 60);
        chk("stray_ferr", n_ferr - bf, 1);
        chk("stray_push_count", push_q.size() - bp, 1);
        chk("stray_push_data", push_q[bp], 8'h33);

        // Reset mid-frame
        bw = wr_addr_q.size(); bf = n_ferr;
        send(8'hAA, 0, 0);
        send(8'h05, 0, 0);
        chk("pre_rst_busy", Busy, 1);
        Reset = 1'b0;
        #1;
        chk("mid_rst_outputs", {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, Tx_FIFO_wr,
                                Tx_FIFO_data, Busy, Frame_error}, 0);
`ifdef RX_CMD_ERR_CNT_EN
        chk("mid_rst_errcnt", Err_count, 0);
`endif
        repeat (2) @(posedge CLK); #1;
        Reset = 1'b1;
        send(8'hAA, 0, 0);
        send(8'h02, 0, 0);
        send(8'h55, 0, 0);
        chk("post_rst_addr", RF_Address, 4'h2);
        chk("post_rst_data", RF_WrData, 8'h55);
        repeat (2) @(posedge CLK); #1;
        chk("post_rst_wr_count", wr_addr_q.size() - bw, 1);
        chk("post_rst_no_ferr", n_ferr - bf, 0);

`ifdef RX_CMD_ERR_CNT_EN
        // Error counter: three aborts, then the clear frame
        send(8'h12, 0, 0);
        send(8'h55, 1, 0);
        send(8'hAA, 0, 0);
        send(8'h07, 0, 1);
        repeat (2) @(posedge CLK); #1;
        chk("errcnt_three", Err_count, 3);
        send(8'hAA, 0, 0);
        send(8'h0F, 0, 0);
        send(8'h00, 0, 0);
        chk("errclr_wren", RF_WrEn, 1);
        chk("errclr_addr", RF_Address, 4'hF);
        chk("errclr_data", RF_WrData, 8'h00);
        chk("errclr_count", Err_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_cmd_ctrl.md
Name: rx_cmd_ctrl

Overview:
- Command sequencer between the UART receiver's parallel output and the system register file / transmit FIFO.
- Collects command frames byte-by-byte from the Rx pulse interface and issues single-cycle register-file writes or reads.
- Pushes read data into the Tx FIFO.
- Drops corrupted or stalled frames, flags them, and returns to idle.

Parameters:
- ADDR_W, 4, register-file address width; address bytes are truncated to the low ADDR_W bits.
- TIMEOUT_CYC, 4096, idle cycles allowed between bytes of one frame before abort (≥2).
- OP_WR, 8'hAA, opcode for single write: OP_WR, addr, data.
- OP_RD, 8'hBB, opcode for single read: OP_RD, addr.
- OP_BRD, 8'hDD, opcode for burst read: OP_BRD, addr, count.

Ports:
- CLK  in  1  system clock
- Reset  in  1  asynchronous active-low reset
- Rx_P_Data  in  8  received byte, valid when Rx_Data_valid=1
- Rx_Data_valid  in  1  one-cycle pulse per received byte
- Rx_Parity_error  in  1  qualifies current Rx byte
- Rx_stop_error  in  1  qualifies current Rx byte
- RF_WrEn  out  1  register-file write strobe
- RF_RdEn  out  1  register-file read strobe
- RF_Address  out  ADDR_W  register-file address
- RF_WrData  out  8  register-file write data
- RF_RdData  in  8  register-file read data
- RF_RdData_valid  in  1  read data valid; arrives ≥1 cycle after RF_RdEn
- Tx_FIFO_wr  out  1  FIFO push strobe
- Tx_FIFO_data  out  8  FIFO push data
- Tx_FIFO_full  in  1  FIFO full
- Busy  out  1  high in any state other than IDLE
- Frame_error  out  1  one-cycle pulse on any frame abort

Behaviour:
- Reset (async, Reset=0):
  - All outputs 0; state IDLE.
  - Internal address, count, timeout counter and read-data register all 0.
  - Reset mid-frame discards the frame with no strobe and no Frame_error.
- Registered outputs: every strobe is high for exactly one cycle.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, BRD_ADDR, BRD_CNT, RD_REQ, RD_WAIT, PUSH.
- "Good byte": Rx_Data_valid=1 and both error flags 0.
- "Bad byte": Rx_Data_valid=1 and either error flag 1.
- IDLE:
  - Good byte equal to OP_WR → WR_ADDR; OP_RD → RD_ADDR; OP_BRD → BRD_ADDR.
  - Any other good byte, or any bad byte → Frame_error pulse, stay IDLE.
- WR_ADDR: good byte → latch low ADDR_W bits → WR_DATA.
- WR_DATA: good byte at cycle T → at T+1 RF_WrEn=1 with RF_Address and RF_WrData=byte → IDLE.
- RD_ADDR: good byte → latch address, count=1 → RD_REQ.
- BRD_ADDR: good byte → latch address → BRD_CNT.
- BRD_CNT:
  - Good byte N≠0 → count=N → RD_REQ.
  - N=0 → Frame_error, IDLE, no reads.
- RD_REQ: RF_RdEn=1 for one cycle with RF_Address → RD_WAIT.
- RD_WAIT: RF_RdData_valid=1 → capture RF_RdData → PUSH.
- PUSH:
  - If Tx_FIFO_full=0: Tx_FIFO_wr=1, Tx_FIFO_data=captured byte; count decrements; address increments modulo 2^ADDR_W (15→0 for ADDR_W=4).
  - count becomes 0 → IDLE; otherwise → RD_REQ.
  - If Tx_FIFO_full=1: hold in PUSH with no push and no data loss.
- Bad byte in any frame-collecting state (WR_*, RD_ADDR, BRD_*): abort → IDLE, Frame_error pulse, no RF strobe.
- Timeout:
  - Counter runs in collecting states, cleared on every Rx_Data_valid.
  - Reaching TIMEOUT_CYC → abort → IDLE, Frame_error.
  - No timeout in RD_REQ, RD_WAIT or PUSH.
- Rx_Data_valid during RD_REQ, RD_WAIT or PUSH: byte dropped, Frame_error pulse, current read sequence continues.
- Simultaneous timeout expiry and good byte: the byte wins and no abort occurs.

Optional Feature:
- Macro: RX_CMD_ERR_CNT_EN.
- Defined:
  - Extra output Err_count[7:0], reset 0.
  - Increments on every Frame_error pulse; saturates at 8'hFF.
  - Cleared by a good OP_WR frame whose address is all ones and whose data is 8'h00; that frame still performs the write.
- Undefined: port absent; no counter logic.

Test Plan:
- Frame AA,05,3C → one cycle after the data byte: RF_WrEn=1, RF_Address=5, RF_WrData=8'h3C; Busy low afterwards; Frame_error never pulses.
- Frame BB,02 with the register file returning 8'h77 two cycles after RF_RdEn → one RF_RdEn at address 2, one Tx_FIFO_wr with data 8'h77, return to IDLE.
- Frame DD,0E,03 with FIFO full held for 10 cycles during the second push → reads addresses 14, 15, 0 (wrap); three pushes in order; no push while full.
- Frame AA,05 then data byte with Rx_Parity_error=1 → Frame_error pulse, no RF_WrEn, IDLE; next clean frame AA,01,11 writes normally.
- Frame AA,05 then silence for TIMEOUT_CYC cycles → Frame_error pulse, IDLE; unknown opcode 8'h12 in IDLE → Frame_error pulse; DD,00,00 → Frame_error, no RF_RdEn.
- With RX_CMD_ERR_CNT_EN defined: three aborts → Err_count=3; frame AA,0F,00 → RF_WrEn at address 15 and Err_count=0; Reset asserted mid-frame → all outputs 0 immediately.
